// File: rtl/aurora_event_counter_bank_if.sv
// Host-side bundle for the event counter bank: event inputs, control pulses,
// the indexed shadow read port and the status outputs.
interface aurora_event_counter_bank_if #(
    parameter int unsigned NUM_EVENTS = 16,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH  = 6
);
    logic [NUM_EVENTS-1:0] events;
    logic                  clear;
    logic                  snapshot;
    logic [SEL_WIDTH-1:0]  rd_sel;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic [NUM_EVENTS-1:0] ovf_flags;
    logic [NUM_EVENTS-1:0] active_now;
    logic                  any_active;

    modport master (
        output events, clear, snapshot, rd_sel,
        input  rd_data, ovf_flags, active_now, any_active
    );

    modport slave (
        input  events, clear, snapshot, rd_sel,
        output rd_data, ovf_flags, active_now, any_active
    );
endinterface

// File: rtl/aurora_event_counter_bank.sv
// Bank of per-channel event counters with polarity/edge selection, sticky
// overflow flags, atomic snapshot into shadows and a registered read port.
module aurora_event_counter_bank #(
    parameter int unsigned           NUM_EVENTS      = 16,
    parameter int unsigned           CNT_WIDTH       = 32,
    parameter logic [NUM_EVENTS-1:0] ACTIVE_LOW_MASK = '0,
    parameter logic [NUM_EVENTS-1:0] EDGE_MASK       = '0,
    parameter bit                    SATURATE        = 1'b1,
    parameter int unsigned           SEL_WIDTH       = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    aurora_event_counter_bank_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_EVENTS-1:0] active_q;
    logic [NUM_EVENTS-1:0] active_prev;
    logic [NUM_EVENTS-1:0] inc;
    logic [NUM_EVENTS-1:0] ovf_q;
    logic                  any_q;
    logic [CNT_WIDTH-1:0]  live   [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  shadow [NUM_EVENTS];
    logic [SEL_WIDTH-1:0]  rd_sel_q;
    logic [CNT_WIDTH-1:0]  rd_mux;
    logic [CNT_WIDTH-1:0]  rd_data_q;

    // Edge channels mask out cycles where the condition was already active.
    assign inc = active_q & ~(active_prev & EDGE_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= '0;
            active_prev <= '0;
            any_q       <= 1'b0;
        end else begin
            active_q    <= bus.events ^ ACTIVE_LOW_MASK;
            active_prev <= active_q;
            any_q       <= |(bus.events ^ ACTIVE_LOW_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                // Shadows take the value from before this edge's update.
                if (bus.snapshot) begin
                    shadow[i] <= live[i];
                end
                if (bus.clear) begin
                    live[i]  <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (inc[i]) begin
                    if (live[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
                        if (!SATURATE) begin
                            live[i] <= '0;
                        end
                    end else begin
                        live[i] <= live[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Indices without a matching channel fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_sel_q == SEL_WIDTH'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_sel_q  <= bus.rd_sel;
            rd_data_q <= rd_mux;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.ovf_flags  = ovf_q;
    assign bus.active_now = active_q;
    assign bus.any_active = any_q;
endmodule

// File: doc/aurora_event_counter_bank.md
Name: aurora_event_counter_bank

Overview:
- Parametrised successor to the fixed-function Aurora flow monitor: a bank of NUM_EVENTS independent event counters driven by an event vector of arbitrary width.
- Per-channel polarity and per-channel level/edge counting mode.
- Saturating or wrapping counters with sticky overflow flags, global clear, atomic snapshot, and a registered indexed read port.
- Sits beside the Aurora core and its FIFOs in the user clock domain; feeds the host-visible status registers.

Parameters:
- NUM_EVENTS, 16: number of event channels (1..64).
- CNT_WIDTH, 32: counter width in bits (2..48).
- ACTIVE_LOW_MASK, 16'h0000: bit i = 1 means channel i is active when events[i] == 0 (e.g. channel_up, pll_lock).
- EDGE_MASK, 16'h0000: bit i = 1 counts rising edges of the active condition; bit i = 0 counts cycles the condition is active.
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- SEL_WIDTH, 6: width of rd_sel; must satisfy 2^SEL_WIDTH >= NUM_EVENTS.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- events  in  NUM_EVENTS  raw status/event inputs; synchronous to clk.
- clear  in  1  one-cycle pulse; zeroes all live counters and sticky flags.
- snapshot  in  1  one-cycle pulse; copies all live counters into shadow registers.
- rd_sel  in  SEL_WIDTH  shadow register index.
- rd_data  out  CNT_WIDTH  shadow[rd_sel]; registered.
- ovf_flags  out  NUM_EVENTS  sticky per-channel saturate/wrap flag.
- active_now  out  NUM_EVENTS  registered active condition per channel.
- any_active  out  1  OR of active_now.

Behaviour:
- Reset (rst = 1 at a posedge): clears all live counters, shadows, ovf_flags, active_now, the previous-active register, rd_data and the registered rd_sel to 0. rst overrides clear, snapshot and events.
- Input stage: active_now[i] <= events[i] ^ ACTIVE_LOW_MASK[i], registered once.
- inc[i] is combinational from the registered state:
  - Level mode: inc[i] = active_now[i].
  - Edge mode: inc[i] = active_now[i] & ~active_prev[i]. active_prev resets to 0, so a condition that is already active after reset counts exactly one edge.
- Latency: an event level present before posedge k is in active_now after k. The counter shows the increment after posedge k+1. A level held for N consecutive sampling edges adds N in level mode and 1 in edge mode.
- Counter update, per channel, in priority order:
  1. clear: counter <= 0; any coincident inc is dropped.
  2. inc with counter == all-ones:
     - SATURATE = 1: hold; ovf_flags[i] <= 1.
     - SATURATE = 0: counter <= 0; ovf_flags[i] <= 1.
  3. inc otherwise: counter + 1.
- ovf_flags are cleared only by clear or rst. If overflow and clear coincide, clear wins and the flag ends 0.
- Snapshot: shadow[i] <= live counter value before the same edge's update, all channels atomically. With snapshot and clear in the same cycle, shadows get the pre-clear values and live counters go to 0. Shadows are unaffected by clear.
- Read port: rd_sel is registered at edge k. rd_data = shadow[rd_sel_q] is valid after edge k+1 (2-cycle latency from rd_sel). rd_sel_q >= NUM_EVENTS returns 0. A snapshot at edge k+1 is not yet reflected at k+1; it is seen one cycle later.
- any_active is the registered OR of the same-edge active values; it is aligned with active_now.
- No handshakes: clear and snapshot are accepted every cycle. Back-to-back pulses are legal, and a level held high acts on every cycle.

Test Plan:
- Reset: hold rst for 2 cycles with events toggling → every rd_data index, ovf_flags, active_now and any_active read 0.
- Level mode, channel 0: events[0] high for exactly 3 sampling edges, then snapshot, rd_sel = 0 → rd_data = 3. Same stimulus on channel 1 with EDGE_MASK[1] = 1 → rd_data = 1 at rd_sel = 1.
- Polarity, ACTIVE_LOW_MASK[2] = 1: hold events[2] high 10 cycles → count 0; drive low 4 cycles → count 4. Two low pulses of 2 cycles each on an edge-mode active-low channel → 2.
- Saturation, CNT_WIDTH = 4, SATURATE = 1: 20 active cycles → counter 15, ovf_flags[0] = 1. With SATURATE = 0, 17 cycles → counter 1, flag 1. Then clear → counter 0, flag 0.
- Simultaneity: counter at 7 with inc, clear and snapshot in the same cycle → shadow = 7, live = 0. A following snapshot reads 0.
- Read port: rd_sel = NUM_EVENTS → rd_data = 0 two cycles later. Sweep rd_sel 0..NUM_EVENTS-1 each cycle → data matches the shadows with 2-cycle latency.
- Reset mid-count: rst asserted while channels are active → all counters 0 the next cycle. An edge-mode channel still active after rst deasserts counts 1.
